sha1_stream_ctrl: RTL and testbench

//  Front-end driver for sha1_core: accepts a message as a 32-bit big-endian word stream,

---
 rtl/sha1_stream_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sha1_stream_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_stream_ctrl.sv
// sha1_stream_ctrl: front end for a single sha1_core instance.
// Takes a big-endian 32-bit word stream and builds 512-bit blocks from it.
// It adds the SHA-1 pad byte and the 64-bit bit length, which may need one extra tail block.
// Each block is issued on the core's start/done handshake, and the chaining value is carried from block to block.
// The final 160-bit digest is published with a one-cycle valid pulse.
module sha1_stream_ctrl #(
  parameter logic [159:0] INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  input  logic [31:0]  i_s_data,
  input  logic         i_s_last,
  input  logic [2:0]   i_s_nbytes,
  output logic         o_core_start,
  output logic [511:0] o_core_data,
  output logic [159:0] o_core_vin,
  input  logic [159:0] i_core_vout,
  input  logic         i_core_done,
  output logic [159:0] o_digest,
  output logic         o_digest_valid
);

  typedef enum logic [2:0] {S_LOAD, S_PAD, S_HASH, S_TAIL, S_DONE} state_t;
  // What still has to follow the block currently being hashed
  typedef enum logic [1:0] {PP_NONE, PP_LEN, PP_P80} pad_t;

  state_t        state;
  state_t        state_n;
  pad_t          pad_pend;
  logic          final_blk;
  logic [4:0]    wcnt;
  logic [6:0]    bc;
  logic [63:0]   bitlen;
  logic [159:0]  h;
  logic [511:0]  blk;

  logic          xfer;
  logic          core_fin;
  logic [2:0]    nb_clamp;
  logic [6:0]    bc_in;
  logic [511:0]  pad_blk;

  assign o_s_ready   = (state == S_LOAD) & ~i_rst;
  assign xfer        = i_s_valid & o_s_ready;
  // Done is only meaningful once the start cycle is over
  assign core_fin    = (state == S_HASH) & ~o_core_start & i_core_done;
  assign o_core_data = blk;
  assign o_core_vin  = h;

  // Byte count of the incoming word; a last word may carry 0..4 bytes
  always_comb begin
    nb_clamp = 3'd4;
    if (i_s_last && (i_s_nbytes < 3'd4))
      nb_clamp = i_s_nbytes;
    bc_in = {wcnt, 2'b00} + {4'd0, nb_clamp};
  end

  // Padded view of the current block: 0x80 at byte bc, zeros after, length if it fits
  always_comb begin
    pad_blk = blk;
    if (bc < 7'd64) begin
      for (int i = 0; i < 64; i++) begin
        if (7'(i) == bc)
          pad_blk[511 - 8*i -: 8] = 8'h80;
        else if (7'(i) > bc)
          pad_blk[511 - 8*i -: 8] = 8'h00;
      end
      if (bc <= 7'd55)
        pad_blk[63:0] = bitlen;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= S_LOAD;
    else
      state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_LOAD: begin
        if (xfer) begin
          if (i_s_last)
            state_n = S_PAD;
          else if (wcnt == 5'd15)
            state_n = S_HASH;
        end
      end
      S_PAD:  state_n = S_HASH;
      S_HASH: begin
        if (core_fin) begin
          if (final_blk)
            state_n = S_DONE;
          else if (pad_pend != PP_NONE)
            state_n = S_TAIL;
          else
            state_n = S_LOAD;
        end
      end
      S_TAIL: state_n = S_HASH;
      S_DONE: state_n = S_LOAD;
      default: state_n = S_LOAD;
    endcase
  end

  // Block buffer, length, chaining value, padding bookkeeping and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wcnt           <= 5'd0;
      bc             <= 7'd0;
      bitlen         <= 64'd0;
      h              <= INIT;
      blk            <= '0;
      final_blk      <= 1'b0;
      pad_pend       <= PP_NONE;
      o_core_start   <= 1'b0;
      o_digest       <= '0;
      o_digest_valid <= 1'b0;
    end else begin
      o_core_start   <= (state_n == S_HASH) && (state != S_HASH);
      o_digest_valid <= (state == S_DONE);
      case (state)
        S_LOAD: begin
          if (xfer) begin
            blk[9'd511 - {wcnt[3:0], 5'd0} -: 32] <= i_s_data;
            wcnt   <= wcnt + 5'd1;
            bitlen <= bitlen + {58'd0, nb_clamp, 3'd0};
            if (i_s_last) begin
              bc <= bc_in;
            end else if (wcnt == 5'd15) begin
              final_blk <= 1'b0;
              pad_pend  <= PP_NONE;
            end
          end
        end
        S_PAD: begin
          blk <= pad_blk;
          if (bc <= 7'd55) begin
            final_blk <= 1'b1;
            pad_pend  <= PP_NONE;
          end else if (bc < 7'd64) begin
            final_blk <= 1'b0;
            pad_pend  <= PP_LEN;
          end else begin
            final_blk <= 1'b0;
            pad_pend  <= PP_P80;
          end
        end
        S_HASH: begin
          if (core_fin) begin
            h    <= i_core_vout;
            wcnt <= 5'd0;
            // Pre-build the tail block here so S_TAIL only has to flip the flags
            if (!final_blk && (pad_pend != PP_NONE))
              blk <= {(pad_pend == PP_P80) ? 32'h8000_0000 : 32'h0, 416'd0, bitlen};
            else
              blk <= '0;
          end
        end
        S_TAIL: begin
          final_blk <= 1'b1;
          pad_pend  <= PP_NONE;
        end
        S_DONE: begin
          o_digest  <= h;
          h         <= INIT;
          bitlen    <= 64'd0;
          final_blk <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_stream_ctrl.sv
// Testbench for sha1_stream_ctrl: emulates sha1_core with a behavioural SHA-1
// compression function and checks issued blocks, chaining and digests against
// a byte-level SHA-1 padding model.
module tb_sha1_stream_ctrl;

  localparam logic [159:0] INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [2:0]   s_nbytes;
  logic         core_start;
  logic [511:0] core_data;
  logic [159:0] core_vin;
  logic [159:0] core_vout;
  logic         core_done;
  logic [159:0] digest;
  logic         digest_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit core_level = 0;
  int core_maxdly = 2;

  byte unsigned msg[$];
  logic [511:0] cap_blk[$];
  logic [159:0] cap_vin[$];
  logic [511:0] exp_blk[$];
  logic [159:0] exp_vin[$];

  sha1_stream_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_s_valid      (s_valid),
    .o_s_ready      (s_ready),
    .i_s_data       (s_data),
    .i_s_last       (s_last),
    .i_s_nbytes     (s_nbytes),
    .o_core_start   (core_start),
    .o_core_data    (core_data),
    .o_core_vin     (core_vin),
    .i_core_vout    (core_vout),
    .i_core_done    (core_done),
    .o_digest       (digest),
    .o_digest_valid (digest_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [159:0] sha1_f(input logic [511:0] b, input logic [159:0] hin);
    logic [31:0] w [0:79];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = hin[159:128]; bb = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = bb ^ c ^ d;                    k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + bb, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // sha1_core stand-in: latches block on start, answers after a random delay,
  // done either as a one-cycle pulse or held high until the next start
  initial begin
    bit busy;
    int cnt;
    logic [511:0] eb;
    logic [159:0] ev;
    busy = 0; cnt = 0; eb = '0; ev = '0;
    core_done = 1'b0;
    core_vout = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        core_done = 1'b0;
        core_vout = rnd160();
      end else if (core_start) begin
        cap_blk.push_back(core_data);
        cap_vin.push_back(core_vin);
        eb = core_data; ev = core_vin; busy = 1;
        cnt = int'($urandom_range(core_maxdly, 0));
        if (!core_level) begin core_done = 1'b0; core_vout = rnd160(); end
      end else if (busy) begin
        if (cnt == 0) begin
          core_vout = sha1_f(eb, ev);
          core_done = 1'b1;
          busy = 0;
          last_done_cyc = cyc;
        end else begin
          cnt--;
          core_done = 1'b0;
          core_vout = rnd160();
        end
      end else if (!core_level) begin
        core_done = 1'b0;
        core_vout = rnd160();
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(8'(s[i]));
  endtask

  task automatic set_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Standard SHA-1 message padding at byte level, then block split and chaining
  task automatic model(output logic [159:0] dig);
    byte unsigned p[$];
    logic [63:0] bl;
    logic [511:0] x;
    logic [159:0] hh;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_blk.delete(); exp_vin.delete();
    hh = INIT;
    x = '0;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) x[511 - 8*j -: 8] = p[64*b + j];
      exp_blk.push_back(x);
      exp_vin.push_back(hh);
      hh = sha1_f(x, hh);
    end
    dig = hh;
  endtask

  task automatic send_words(input string tag, input bit rnd);
    int nw, nbl, idx, guard;
    logic [31:0] wd;
    nw = (msg.size() + 3) / 4;
    if (nw == 0) nw = 1;
    nbl = msg.size() - 4 * (nw - 1);
    if (rnd && msg.size() > 0 && nbl == 4 && ($urandom % 2 == 1)) begin
      nw++;
      nbl = 0;
    end
    idx = 0; guard = 0; wd = '0;
    while (idx < nw && guard < 20000) begin
      @(negedge clk);
      guard++;
      s_valid = rnd ? ($urandom % 4 != 0) : 1'b1;
      for (int j = 0; j < 4; j++)
        wd[31 - 8*j -: 8] = (4*idx + j < msg.size()) ? msg[4*idx + j] : 8'($urandom);
      s_data = s_valid ? wd : $urandom;
      s_last = s_valid ? (idx == nw - 1) : 1'($urandom);
      if (s_valid && idx == nw - 1)
        s_nbytes = (nbl == 4 && rnd) ? 3'(4 + $urandom % 4) : 3'(nbl);
      else
        s_nbytes = 3'($urandom);
      if (s_valid && s_ready) idx++;
    end
    chk({tag, " words_accepted"}, 512'(idx), 512'(nw));
  endtask

  task automatic collect(input string tag, input bit has_known, input logic [159:0] known);
    logic [159:0] dig, edig;
    bit got, rdy_bad;
    int dcyc;
    model(edig);
    got = 0; rdy_bad = 0; dig = '0; dcyc = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      if (digest_valid) begin
        got = 1; dig = digest; dcyc = cyc; s_valid = 1'b0;
      end else begin
        if (s_ready) rdy_bad = 1;
        s_valid  = 1'($urandom);
        s_data   = $urandom;
        s_last   = 1'($urandom);
        s_nbytes = 3'($urandom);
      end
    end
    chk({tag, " digest_seen"}, 512'(got), 512'(1));
    chk({tag, " ready_stall"}, 512'(rdy_bad), 512'(0));
    chk({tag, " nblocks"}, 512'(cap_blk.size()), 512'(exp_blk.size()));
    for (int b = 0; b < exp_blk.size() && b < cap_blk.size(); b++) begin
      chk($sformatf("%s blk%0d data", tag, b), cap_blk[b], exp_blk[b]);
      chk($sformatf("%s blk%0d vin", tag, b), 512'(cap_vin[b]), 512'(exp_vin[b]));
    end
    chk({tag, " digest_model"}, 512'(dig), 512'(edig));
    if (has_known) chk({tag, " digest_vector"}, 512'(dig), 512'(known));
    chk({tag, " latency"}, 512'(dcyc), 512'(last_done_cyc + 2));
    @(negedge clk);
    chk({tag, " pulse_1cyc"}, 512'(digest_valid), 512'(0));
    chk({tag, " digest_hold"}, 512'(digest), 512'(edig));
  endtask

  task automatic run_msg(input string tag, input bit rnd, input bit has_known, input logic [159:0] known);
    cap_blk.delete(); cap_vin.delete();
    send_words(tag, rnd);
    collect(tag, has_known, known);
  endtask

  initial begin
    string s;
    int lens[7];
    bit seen, bad;
    lens = '{55, 56, 63, 64, 65, 119, 120};
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0;

    // Reset state
    @(negedge clk);
    chk("rst ready", 512'(s_ready), 512'(0));
    chk("rst start", 512'(core_start), 512'(0));
    chk("rst dvalid", 512'(digest_valid), 512'(0));
    chk("rst digest", 512'(digest), 512'(0));
    chk("rst cdata", core_data, 512'(0));
    chk("rst vin", 512'(core_vin), 512'(INIT));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", 512'(s_ready), 512'(1));

    // "abc"
    core_level = 0; core_maxdly = 3;
    set_str("abc");
    run_msg("abc", 0, 1, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
    chk("abc block", cap_blk[0], {32'h61626380, 416'h0, 64'h18});

    // 80 digits, held done
    core_level = 1;
    s = "";
    for (int i = 0; i < 8; i++) s = {s, "1234567890"};
    set_str(s);
    run_msg("digits", 0, 1, 160'h50abf570_6a150990_a08b2c5e_a40fa0e5_85554732);
    chk("digits blk1 len", 512'(cap_blk[1][63:0]), 512'(64'h280));
    chk("digits vin chain", 512'(cap_vin[1]), 512'(sha1_f(cap_blk[0], INIT)));

    // 56 bytes: length spills into a tail block
    core_level = 0;
    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg("len56", 0, 1, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
    chk("len56 tail", cap_blk[1], {448'h0, 64'h1c0});

    // 64 bytes: pad byte and length both go to the tail block
    set_rand(64);
    run_msg("len64", 0, 0, '0);
    chk("len64 tail", cap_blk[1], {32'h80000000, 416'h0, 64'h200});

    // Empty message
    set_str("");
    run_msg("empty", 0, 1, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);
    chk("empty block", cap_blk[0], {32'h80000000, 480'h0});

    // Back-to-back randomized messages, boundary lengths first
    for (int m = 0; m < 16; m++) begin
      core_level  = 1'($urandom);
      core_maxdly = int'($urandom_range(5, 0));
      set_rand(m < 7 ? lens[m] : int'($urandom_range(150, 0)));
      run_msg($sformatf("rnd%0d_len%0d", m, msg.size()), 1, 0, '0);
    end

    // Reset while the core is busy
    core_level = 1; core_maxdly = 6;
    set_rand(80);
    cap_blk.delete(); cap_vin.delete();
    send_words("rst_mid", 0);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (core_start) seen = 1;
    end
    chk("rst_mid start_seen", 512'(seen), 512'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid ready", 512'(s_ready), 512'(0));
    chk("rst_mid start", 512'(core_start), 512'(0));
    chk("rst_mid digest", 512'(digest), 512'(0));
    chk("rst_mid cdata", core_data, 512'(0));
    chk("rst_mid vin", 512'(core_vin), 512'(INIT));
    @(negedge clk);
    chk("rst_mid dvalid", 512'(digest_valid), 512'(0));
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (digest_valid) bad = 1;
    end
    chk("rst_mid no_digest", 512'(bad), 512'(0));
    chk("rst_mid ready_back", 512'(s_ready), 512'(1));

    core_level = 0; core_maxdly = 2;
    set_str("abc");
    run_msg("abc_after_rst", 1, 1, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
